// File: rtl/count_pkg.sv
// Shared definitions for the 8-bit up/down counter family.
package count_pkg;

    localparam int CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_t;

endpackage

// File: rtl/count8_down_if.sv
// Control/status bundle of the down-counter; master drives control, slave is the counter.
interface count8_down_if import count_pkg::*; #(
    parameter int WIDTH = CNT_WIDTH
);
    logic             EN;
    logic             load;
    logic [WIDTH-1:0] CNT_In;
    logic             auto;
    logic [WIDTH-1:0] CNT;
    logic             TC;
    logic             busy;
    logic             done;

    modport master (
        output EN, load, CNT_In, auto,
        input  CNT, TC, busy, done
    );

    modport slave (
        input  EN, load, CNT_In, auto,
        output CNT, TC, busy, done
    );
endinterface

// File: rtl/count8_down.sv
// Loadable down-counter/timer: counts a loaded value to zero, pulses TC at the
// terminal step and optionally reloads from the captured reload value.
module count8_down import count_pkg::*; #(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic         clk,
    input  logic         res,
    count8_down_if.slave bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic [1:0]       state_q, state_d;
    logic             tc_q, tc_d;

    always_comb begin
        cnt_d   = cnt_q;
        rld_d   = rld_q;
        state_d = state_q;
        tc_d    = 1'b0;
        if (bus.load) begin
            cnt_d   = bus.CNT_In;
            rld_d   = bus.CNT_In;
            state_d = (bus.CNT_In != '0) ? ST_RUN : ST_IDLE;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.EN) begin
                        // Treat <=1 as terminal so an impossible zero in RUN can never wrap.
                        if (cnt_q <= WIDTH'(1)) begin
                            tc_d = 1'b1;
                            if (bus.auto) begin
                                cnt_d = rld_q;
                            end else begin
                                cnt_d   = '0;
                                state_d = ST_DONE;
                            end
                        end else begin
                            cnt_d = cnt_q - WIDTH'(1);
                        end
                    end
                end
                ST_DONE: cnt_d = '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cnt_q   <= '0;
            rld_q   <= '0;
            state_q <= ST_IDLE;
            tc_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rld_q   <= rld_d;
            state_q <= state_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.CNT  = cnt_q;
    assign bus.TC   = tc_q;
    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);

endmodule

// File: tb/tb_count8_down.sv
// Scoreboard bench for count8_down: stimulus queues expected post-edge outputs,
// a monitor pops and compares them after every rising edge.
module tb_count8_down;
    import count_pkg::*;

    typedef struct {
        string      name;
        logic [7:0] cnt;
        logic       tc;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk = 1'b0;
    logic res = 1'b0;
    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    count8_down_if #(.WIDTH(8)) bus ();

    count8_down #(.WIDTH(8)) dut (
        .clk (clk),
        .res (res),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got CNT=%h TC=%b busy=%b done=%b, want CNT=%h TC=%b busy=%b done=%b",
                     name, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Monitor: outputs are registered, so check shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            compare(e.name, {bus.CNT, bus.TC, bus.busy, bus.done},
                    {e.cnt, e.tc, e.busy, e.done});
        end
    end

    task automatic step(input string name, input logic en, input logic ld, input logic [7:0] din,
                        input logic au, input logic [7:0] ecnt, input logic etc,
                        input logic ebusy, input logic edone);
        exp_t e;
        @(negedge clk);
        bus.EN     = en;
        bus.load   = ld;
        bus.CNT_In = din;
        bus.auto   = au;
        e.name = name; e.cnt = ecnt; e.tc = etc; e.busy = ebusy; e.done = edone;
        sb_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic drain();
        int budget;
        budget = 10;
        while (sb_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #3;
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        bus.EN = 1'b0; bus.load = 1'b1; bus.CNT_In = 8'h55; bus.auto = 1'b0;

        // Reset dominates a pending load
        step("rst_hold0", 1'b0, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step("rst_hold1", 1'b0, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drain();
        @(negedge clk);
        bus.load = 1'b0;
        res = 1'b1;
        for (int i = 0; i < 3; i++)
            step("idle_en_ignored", 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // One-shot 5
        step("os_load", 1'b1, 1'b1, 8'h05, 1'b0, 8'h05, 1'b0, 1'b1, 1'b0);
        step("os_04", 1'b1, 1'b0, 8'h00, 1'b0, 8'h04, 1'b0, 1'b1, 1'b0);
        step("os_03", 1'b1, 1'b0, 8'h00, 1'b0, 8'h03, 1'b0, 1'b1, 1'b0);
        step("os_02", 1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0);
        step("os_01", 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0);
        step("os_tc", 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++)
            step("os_done_hold", 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Enable gating, load from DONE re-arms
        step("eg_load", 1'b1, 1'b1, 8'h11, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0);
        step("eg_10", 1'b1, 1'b0, 8'h00, 1'b0, 8'h10, 1'b0, 1'b1, 1'b0);
        step("eg_0f", 1'b1, 1'b0, 8'h00, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b0);
        step("eg_0e", 1'b1, 1'b0, 8'h00, 1'b0, 8'h0E, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            step("eg_hold", 1'b0, 1'b0, 8'h00, 1'b0, 8'h0E, 1'b0, 1'b1, 1'b0);
        step("eg_0d", 1'b1, 1'b0, 8'h00, 1'b0, 8'h0D, 1'b0, 1'b1, 1'b0);

        // Auto-reload period 3
        step("ar_load", 1'b1, 1'b1, 8'h03, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0);
        for (int r = 0; r < 2; r++) begin
            step("ar_02", 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0);
            step("ar_01", 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
            step("ar_tc", 1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 1'b1, 1'b0);
        end

        // Load colliding with the terminal step, then load of zero
        step("co_02", 1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0);
        step("co_01", 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0);
        step("co_load20", 1'b1, 1'b1, 8'h20, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0);
        step("co_load00", 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step("co_idle", 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Auto period 1: TC every enabled cycle
        step("p1_load", 1'b1, 1'b1, 8'h01, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
        step("p1_tc0", 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0);
        step("p1_tc1", 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0);
        step("p1_gate", 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);

        // Reset mid-count
        step("rm_load", 1'b1, 1'b1, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 10; i++)
            step("rm_cnt", 1'b1, 1'b0, 8'h00, 1'b0, 8'(8'hFF - i), 1'b0, 1'b1, 1'b0);
        drain();
        @(negedge clk);
        #1 res = 1'b0;
        #1 compare("rm_async", {bus.CNT, bus.TC, bus.busy, bus.done}, {8'h00, 1'b0, 1'b0, 1'b0});
        #1 res = 1'b1;
        for (int i = 0; i < 3; i++)
            step("rm_idle", 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step("rm_reload", 1'b1, 1'b1, 8'h07, 1'b0, 8'h07, 1'b0, 1'b1, 1'b0);
        step("rm_06", 1'b1, 1'b0, 8'h00, 1'b0, 8'h06, 1'b0, 1'b1, 1'b0);

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
